// File: rtl/odd_detector_pkg.sv
// rtl/odd_detector_pkg.sv - shared state encoding and default sizes for the odd detector
package odd_detector_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_N  = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INGEST = 2'd1,
    ST_VERIFY = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/odd_detector_stream_if.sv
// rtl/odd_detector_stream_if.sv - input word stream and result handshake of the odd detector
interface odd_detector_stream_if
  import odd_detector_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = $clog2(DEF_MAX_N + 1)
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_value;
  logic [CNT_W-1:0]  out_count;
  logic              out_odd;
  logic              out_error;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_value, out_count, out_odd, out_error, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_value, out_count, out_odd, out_error, out_valid
  );

endinterface

// File: rtl/odd_sample_ram.sv
// rtl/odd_sample_ram.sv - frame buffer: one synchronous write port, one asynchronous read port
module odd_sample_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/odd_detector_stream.sv
// rtl/odd_detector_stream.sv - buffers a frame, XOR-reduces it, then re-scans to count the candidate
module odd_detector_stream
  import odd_detector_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_N  = DEF_MAX_N,
  parameter int CNT_W  = $clog2(MAX_N + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_n,
  output logic             o_busy,
  odd_detector_stream_if.slave bus
);

  localparam int ADDR_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] MAX_N_C = CNT_W'(MAX_N);

  state_t            r_state;
  logic [CNT_W-1:0]  r_n;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic [DATA_W-1:0] w_rd_data;
  logic              w_wr_en;
  logic              w_n_ok;
  logic              w_idx_last;
  logic              w_hit;

  assign w_wr_en    = (r_state == ST_INGEST) && bus.in_valid;
  assign w_n_ok     = (i_n != '0) && (i_n <= MAX_N_C);
  assign w_idx_last = (r_idx == r_n - CNT_W'(1));
  assign w_hit      = (w_rd_data == r_acc);

  odd_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_N),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_idx[ADDR_W-1:0]),
    .i_wr_data (bus.in_data),
    .i_rd_addr (r_idx[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (i_clear) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc <= '0;
            r_idx <= '0;
            r_cnt <= '0;
            if (w_n_ok) begin
              r_n     <= i_n;
              r_err   <= 1'b0;
              r_state <= ST_INGEST;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_OUTPUT;
            end
          end
        end
        ST_INGEST: begin
          if (bus.in_valid) begin
            r_acc <= r_acc ^ bus.in_data;
            if (w_idx_last) begin
              r_idx   <= '0;
              r_cnt   <= '0;
              r_state <= ST_VERIFY;
            end else begin
              r_idx <= r_idx + CNT_W'(1);
            end
          end
        end
        ST_VERIFY: begin
          // acc is final here, so each buffered word is compared against the candidate
          r_cnt <= r_cnt + CNT_W'(w_hit);
          r_idx <= r_idx + CNT_W'(1);
          if (w_idx_last) r_state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign bus.in_ready  = (r_state == ST_INGEST);
  assign bus.out_valid = (r_state == ST_OUTPUT);
  assign bus.out_value = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_odd   = r_cnt[0];
  assign bus.out_error = r_err;

endmodule
